// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, flag positions and the response record
// carried from the shared ALU into each requester's buffer.
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int NUM_REQ = 2;
   localparam int CTRL_W  = 4;

   localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
   localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
   localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b1100;
   localparam logic [CTRL_W-1:0] ALU_NAND = 4'b1101;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [3:0]        nzcv;
      logic              err;
   } rsp_t;

   function automatic logic is_legal_ctrl(input logic [CTRL_W-1:0] ctrl);
      case (ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
         ALU_SLT, ALU_NOR, ALU_NAND: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ALU.sv
// Combinational ALU. Unknown control codes produce result 0, so flags read NZCV=0100.
// C is carry-out for ADD and not-borrow for SUB; logic ops and SLT leave C and V clear.
module ALU
   import alu_pkg::*;
(
   input  logic [CTRL_W-1:0] ctrl,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        nzcv
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;
   logic            carry;
   logic            ovf;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (ctrl)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_ADD: begin
            result = sum[MSB:0];
            carry  = sum[DATA_W];
            ovf    = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
         end
         ALU_SUB: begin
            result = diff[MSB:0];
            carry  = diff[DATA_W];
            ovf    = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
         end
         ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_NOR:  result = ~(a | b);
         ALU_NAND: result = ~(a & b);
         default:  result = '0;
      endcase
      nzcv         = '0;
      nzcv[FLAG_N] = result[MSB];
      nzcv[FLAG_Z] = (result == '0);
      nzcv[FLAG_C] = carry;
      nzcv[FLAG_V] = ovf;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, each with a one-entry
// response buffer that may drain and reload in the same cycle.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0]   req_srcA_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_srcB_i,
   input  logic [NUM_REQ*CTRL_W-1:0]   req_ctrl_i,
   output logic [NUM_REQ-1:0]          rsp_valid_o,
   input  logic [NUM_REQ-1:0]          rsp_ready_i,
   output logic [NUM_REQ*DATA_W-1:0]   rsp_result_o,
   output logic [NUM_REQ*4-1:0]        rsp_nzcv_o,
   output logic [NUM_REQ-1:0]          rsp_err_o
);

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] grant;
   logic               last_grant_reg;
   logic               sel;
   logic [DATA_W-1:0]  alu_a;
   logic [DATA_W-1:0]  alu_b;
   logic [CTRL_W-1:0]  alu_ctrl;
   logic [DATA_W-1:0]  alu_result;
   logic [3:0]         alu_nzcv;
   rsp_t               alu_rsp;

   // Tie goes to the requester that did not win last; reset suppresses any grant.
   always_comb begin
      grant = '0;
      if (!rst_i) begin
         if (elig == 2'b11) grant = last_grant_reg ? 2'b01 : 2'b10;
         else               grant = elig;
      end
   end

   assign req_ready_o = grant;
   assign sel         = grant[1];

   always_ff @(posedge clk_i) begin
      if (rst_i)        last_grant_reg <= 1'b1;
      else if (|grant)  last_grant_reg <= grant[1];
   end

   assign alu_a    = sel ? req_srcA_i[2*DATA_W-1:DATA_W] : req_srcA_i[DATA_W-1:0];
   assign alu_b    = sel ? req_srcB_i[2*DATA_W-1:DATA_W] : req_srcB_i[DATA_W-1:0];
   assign alu_ctrl = sel ? req_ctrl_i[2*CTRL_W-1:CTRL_W] : req_ctrl_i[CTRL_W-1:0];

   ALU u_alu (
      .ctrl   (alu_ctrl),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_result),
      .nzcv   (alu_nzcv)
   );

   assign alu_rsp.result = alu_result;
   assign alu_rsp.nzcv   = alu_nzcv;
   assign alu_rsp.err    = ~is_legal_ctrl(alu_ctrl);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
         rsp_t rsp_reg;
         logic valid_reg;

         assign elig[gi] = req_valid_i[gi] & (~valid_reg | rsp_ready_i[gi]);

         always_ff @(posedge clk_i) begin
            if (rst_i)                valid_reg <= 1'b0;
            else if (grant[gi])       valid_reg <= 1'b1;
            else if (rsp_ready_i[gi]) valid_reg <= 1'b0;
         end

         // Payload is only meaningful under valid, so it carries no reset.
         always_ff @(posedge clk_i) begin
            if (grant[gi]) rsp_reg <= alu_rsp;
         end

         assign rsp_valid_o[gi]                    = valid_reg;
         assign rsp_result_o[gi*DATA_W +: DATA_W]  = rsp_reg.result;
         assign rsp_nzcv_o[gi*4 +: 4]              = rsp_reg.nzcv;
         assign rsp_err_o[gi]                      = rsp_reg.err;
      end
   endgenerate

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational `ALU` instance between two requesters, such as a fetch/branch unit and an execute unit. Requests use a valid/ready handshake and are granted round-robin, at most one per cycle. Each granted result, with its NZCV flags and an illegal-opcode flag, is captured in a one-entry response buffer owned by that requester. The response is presented with its own valid/ready handshake, one cycle after acceptance.

## Interface
Parameters:
- `DATA_W`, default 32: operand/result width; fixed by `ALU`, not overridable.
- `NUM_REQ`, default 2: number of requesters; fixed at 2.

Ports. Requester k occupies bit k of the 1-bit vectors, bits [32k+31:32k] of the data vectors, [4k+3:4k] of the 4-bit vectors.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  2  request valid per requester.
- `req_ready_o`  out  2  request accepted this cycle (grant).
- `req_srcA_i`  in  64  source A per requester.
- `req_srcB_i`  in  64  source B per requester.
- `req_ctrl_i`  in  8  4-bit ALU control per requester.
- `rsp_valid_o`  out  2  response buffer holds a result.
- `rsp_ready_i`  in  2  requester consumes response.
- `rsp_result_o`  out  64  32-bit result per requester.
- `rsp_nzcv_o`  out  8  NZCV per requester.
- `rsp_err_o`  out  2  ctrl code was not a legal ALU op.

## Operation
- **Legal ctrl codes:** 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
  - Any other code still passes through `ALU`, which yields result 0 and NZCV 0100.
  - For such codes `rsp_err` = 1.
- **Eligibility:** `elig[k] = req_valid_i[k] & (~rsp_valid_o[k] | rsp_ready_i[k])`. A requester whose buffer is full and not draining this cycle is never granted.
- **Arbitration:** `last_grant` is a 1-bit register holding the index of the last granted requester.
  - Only one eligible: grant it.
  - Both eligible: grant `~last_grant`.
  - None eligible: no grant, and `last_grant` is unchanged.
  - `last_grant` updates only on a grant.
- `req_ready_o` is one-hot or zero, and is combinational from `req_valid_i`, `rsp_valid_o` and `rsp_ready_i`.
- **ALU operand mux:** selects the granted requester's srcA/srcB/ctrl. With no grant it selects requester 0, and the output is ignored.
- **Response buffer k, next state, in priority order:**
  - Grant to k: load result/NZCV/err and set valid. Simultaneous drain and reload is legal, giving back-to-back responses.
  - Otherwise `rsp_ready_i[k]`: clear valid.
  - Otherwise hold. Data stays stable while `valid & ~ready`.
- `rsp_ready_i[k]` while `rsp_valid_o[k]` = 0 has no effect.
- Response data registers are not reset. Only the valid bits and `last_grant` are reset.

## Timing
- **Reset values:**
  - `rsp_valid_o` = 00 and `last_grant` = 1, so requester 0 wins the first tie.
  - `req_ready_o` = 00 in the reset cycle; the grant logic is gated by `rst_i`.
  - `rsp_result_o`/`rsp_nzcv_o`/`rsp_err_o` are don't-care while the corresponding valid = 0.
- **Latency:** a request accepted at edge t (`valid & ready` high) appears with `rsp_valid_o` = 1 after edge t, in cycle t+1.
- **Throughput:**
  - Aggregate: 1 op/cycle.
  - Per requester: 1 op/cycle if its consumer holds ready high.
  - Under continuous contention each requester gets every other cycle.
- **Reset mid-operation:** pending responses are discarded, and no grant is issued in the reset cycle.
- A requester must hold valid and its operands stable until `req_ready_o` is seen (standard handshake). The block does not check this.

## Structure
- Shared package `alu_pkg`:
  - ALU ctrl code constants (`ALU_AND` .. `ALU_NAND`).
  - NZCV bit indices (N=3, Z=2, C=1, V=0).
  - An `is_legal_ctrl` function.
- Sub-module: one instance of the existing `ALU`. Everything else (arbiter, response buffers) is inline.

## Test plan
- Reset, then requester 0 only: ADD 0x7FFFFFFF+0x00000001 -> `req_ready_o[0]`=1, and next cycle `rsp_valid_o[0]`=1 with result 0x80000000, NZCV 1001, err 0.
- Both valid in the first cycle after reset, requester 0 SUB 5-5, requester 1 SLT 0xFFFFFFFF vs 0x00000001:
  - Cycle 1 grants requester 0. Its response is 0x00000000, NZCV 0110.
  - Cycle 2 grants requester 1. Its response is 0x00000001, NZCV 0000.
- Backpressure: `rsp_ready_i[0]`=0 with requester 0's buffer full and a new request pending -> `req_ready_o[0]`=0 and the buffer data is held constant. Requester 1 continues to be granted every cycle. Raising `rsp_ready_i[0]` grants requester 0 in that same cycle.
- Illegal ctrl 0011 from requester 1 -> result 0, NZCV 0100, `rsp_err_o[1]`=1.
- Continuous both-valid with both readies high for 8 cycles -> grants alternate 0,1,0,1,… and each response matches its own operands.
- `rst_i` asserted while both buffers are valid -> `rsp_valid_o`=00 after the edge. The next tie grants requester 0.
